// File: rtl/btn_pkg.sv
// ---------------------------------------------------------------------------
// btn_pkg
// Shared constants for the APB push-button debouncer:
//   - APB word addresses of every register (PADDR[4:2])
//   - ID register value
//   - debounce counter width and press counter width
//   - bit offset of the release events inside the EVENT register
// ---------------------------------------------------------------------------
package btn_pkg;

    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_EVENT     = 3'd1;
    localparam logic [2:0] ADDR_IRQ_EN    = 3'd2;
    localparam logic [2:0] ADDR_DB_TICKS  = 3'd3;
    localparam logic [2:0] ADDR_PRESS_CNT = 3'd4;
    localparam logic [2:0] ADDR_ID        = 3'd7;

    localparam logic [31:0] ID_VALUE = 32'h4244_0100;

    localparam int CNT_W       = 16;
    localparam int PRESS_CNT_W = 8;
    localparam int EVT_REL_OFS = 8;

endpackage

// File: rtl/btn_debounce_cell.sv
// ---------------------------------------------------------------------------
// btn_debounce_cell
// One button: 2-FF synchroniser, polarity fix, debounce counter and the
// stable level, plus single-cycle press/release pulses that coincide with
// the clock edge on which the stable level changes.
// Ports:
//   PCLK      clock
//   PRESET    async active-high reset
//   pin       raw asynchronous button pin
//   db_ticks  cycles a new level must hold before it is accepted (0 acts as 1)
//   lvl       debounced level, 1 = pressed
//   press     high in the cycle whose closing edge takes lvl 0->1
//   released  high in the cycle whose closing edge takes lvl 1->0
// ---------------------------------------------------------------------------
module btn_debounce_cell
    import btn_pkg::*;
#(
    parameter bit ACT_LOW = 1'b1
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             pin,
    input  logic [CNT_W-1:0] db_ticks,
    output logic             lvl,
    output logic             press,
    output logic             released
);

    logic             sync_0;
    logic             sync_1;
    logic             pin_sync;
    logic [CNT_W-1:0] cnt;
    logic             stable;
    logic [CNT_W-1:0] ticks_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             expire;

    // The synchroniser resets to the raw "released" pin level so that the
    // first cycles after reset never look like a press.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            sync_0 <= ACT_LOW;
            sync_1 <= ACT_LOW;
        end else begin
            sync_0 <= pin;
            sync_1 <= sync_0;
        end
    end

    // After the polarity fix a 1 always means "pressed". A zero threshold is
    // treated as one, and the comparison is done one bit wider so CNT+1
    // cannot wrap.
    assign pin_sync  = sync_1 ^ ACT_LOW;
    assign ticks_eff = (db_ticks == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : db_ticks;
    assign cnt_inc   = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign expire    = (pin_sync != stable) && (cnt_inc >= {1'b0, ticks_eff});

    // Debounce counter: any agreement with the stable level restarts the
    // count; a disagreement that has lasted long enough is accepted. Using >=
    // lets a lowered threshold take effect on a count already in progress.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (pin_sync == stable) begin
            cnt <= '0;
        end else if (expire) begin
            stable <= pin_sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt_inc[CNT_W-1:0];
        end
    end

    assign lvl      = stable;
    assign press    = expire &  pin_sync;
    assign released = expire & ~pin_sync;

endmodule

// File: rtl/apb_btn_debounce.sv
// ---------------------------------------------------------------------------
// apb_btn_debounce
// APB3 target that debounces NUM_BTN push buttons, latches press/release
// events into a write-one-to-clear register and raises a level interrupt.
// Optional feature macro: BTN_PRESS_COUNT_EN adds an 8-bit saturating press
// counter per button, readable at address 4 and cleared by any write there.
// Ports:
//   PCLK, PRESET                 clock, async active-high reset
//   PSEL, PENABLE, PWRITE        APB control
//   PADDR[4:2], PWDATA, PRDATA   APB address / write data / registered read data
//   PREADY, PSLVERR              tied to 1 / 0
//   BTN_IN[NUM_BTN]              raw button pins
//   BTN_LVL[NUM_BTN]             debounced levels, 1 = pressed
//   IRQ                          registered |(EVENT & IRQ_EN)
// Register map: 0 STATUS, 1 EVENT (W1C), 2 IRQ_EN, 3 DB_TICKS,
//               4 PRESS_CNT, 7 ID; everything else reads 0.
// ---------------------------------------------------------------------------
module apb_btn_debounce
    import btn_pkg::*;
#(
    parameter int          NUM_BTN      = 2,
    parameter logic [15:0] DB_RST_TICKS = 16'd50000,
    parameter bit          BTN_ACT_LOW  = 1'b1
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [4:2]         PADDR,
    input  logic [31:0]        PWDATA,
    output logic [31:0]        PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    input  logic [NUM_BTN-1:0] BTN_IN,
    output logic [NUM_BTN-1:0] BTN_LVL,
    output logic               IRQ
);

    logic             wr_en;
    logic             rd_setup;
    logic [15:0]      event_q;
    logic [15:0]      irq_en_q;
    logic [CNT_W-1:0] db_ticks_q;
    logic [15:0]      evt_set;
    logic [15:0]      evt_clr;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] released;
    logic [7:0]       lvl8;
    logic [31:0]      press_cnt_word;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign wr_en    = PSEL & PENABLE & PWRITE;
    assign rd_setup = PSEL & ~PENABLE & ~PWRITE;
    assign PREADY   = 1'b1;
    assign PSLVERR  = 1'b0;
    assign unused_bits = &{1'b0, PWDATA[31:16]};

    // One debounce cell per button, all sharing the DB_TICKS threshold.
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce_cell #(
            .ACT_LOW (BTN_ACT_LOW)
        ) u_cell (
            .PCLK     (PCLK),
            .PRESET   (PRESET),
            .pin      (BTN_IN[i]),
            .db_ticks (db_ticks_q),
            .lvl      (BTN_LVL[i]),
            .press    (press[i]),
            .released (released[i])
        );
    end

    // Gather per-button pulses into EVENT bit positions: presses in the low
    // byte, releases in the high byte.
    always_comb begin
        evt_set = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            evt_set[i]               = press[i];
            evt_set[EVT_REL_OFS + i] = released[i];
        end
    end

    assign evt_clr = (wr_en && (PADDR == ADDR_EVENT)) ? PWDATA[15:0] : 16'h0000;

    // Control/status registers. A new event wins over a same-cycle W1C clear
    // so that no press or release is ever lost to a racing acknowledge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            event_q    <= '0;
            irq_en_q   <= '0;
            db_ticks_q <= DB_RST_TICKS;
        end else begin
            event_q <= (event_q & ~evt_clr) | evt_set;
            if (wr_en && (PADDR == ADDR_IRQ_EN)) begin
                irq_en_q <= PWDATA[15:0];
            end
            if (wr_en && (PADDR == ADDR_DB_TICKS)) begin
                db_ticks_q <= PWDATA[CNT_W-1:0];
            end
        end
    end

`ifdef BTN_PRESS_COUNT_EN
    localparam int CNT_RD = (NUM_BTN < 4) ? NUM_BTN : 4;

    logic [PRESS_CNT_W-1:0] press_cnt [NUM_BTN];
    logic                   cnt_clr;

    assign cnt_clr = wr_en && (PADDR == ADDR_PRESS_CNT);

    // Saturating press counters. A clear that coincides with a press leaves
    // that press counted, so software never misses one across a clear.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                press_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                if (cnt_clr) begin
                    press_cnt[i] <= press[i] ? PRESS_CNT_W'(1) : '0;
                end else if (press[i] && (press_cnt[i] != '1)) begin
                    press_cnt[i] <= press_cnt[i] + PRESS_CNT_W'(1);
                end
            end
        end
    end

    // Only the first four counters fit in the 32-bit read word.
    always_comb begin
        press_cnt_word = '0;
        for (int i = 0; i < CNT_RD; i++) begin
            press_cnt_word[i*PRESS_CNT_W +: PRESS_CNT_W] = press_cnt[i];
        end
    end
`else
    assign press_cnt_word = '0;
`endif

    // Zero-extend the level vector to the STATUS byte.
    always_comb begin
        lvl8 = '0;
        lvl8[NUM_BTN-1:0] = BTN_LVL;
    end

    // Read multiplexer; unmapped addresses and unused upper bits read 0.
    always_comb begin
        rd_mux = '0;
        case (PADDR)
            ADDR_STATUS:    rd_mux = {24'h0, lvl8};
            ADDR_EVENT:     rd_mux = {16'h0, event_q};
            ADDR_IRQ_EN:    rd_mux = {16'h0, irq_en_q};
            ADDR_DB_TICKS:  rd_mux = {16'h0, db_ticks_q};
            ADDR_PRESS_CNT: rd_mux = press_cnt_word;
            ADDR_ID:        rd_mux = ID_VALUE;
            default:        rd_mux = '0;
        endcase
    end

    // Read data is captured in the setup phase so it is stable throughout
    // the access phase; it returns to 0 in every other cycle.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PRDATA <= '0;
        end else if (rd_setup) begin
            PRDATA <= rd_mux;
        end else begin
            PRDATA <= '0;
        end
    end

    // Interrupt is a registered view of the enabled pending events.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            IRQ <= 1'b0;
        end else begin
            IRQ <= |(event_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_apb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_apb_btn_debounce
// Self-checking bench for apb_btn_debounce (NUM_BTN=2, active-low pins).
// Register accesses come from a table; debounce timing, bounce rejection,
// the W1C race, mid-count threshold change, reset mid-debounce and the
// optional press counters (BTN_PRESS_COUNT_EN) use hand-written sequences.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_btn_debounce;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:2]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [1:0]  BTN_IN;
    logic [1:0]  BTN_LVL;
    logic        IRQ;

    int num_checks = 0;
    int num_errors = 0;

    typedef struct {
        logic        is_write;
        logic [2:0]  addr;
        logic [31:0] data;
        string       name;
    } vec_t;

    vec_t vecs [16];

    apb_btn_debounce #(
        .NUM_BTN      (2),
        .DB_RST_TICKS (16'd50000),
        .BTN_ACT_LOW  (1'b1)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .BTN_IN  (BTN_IN),
        .BTN_LVL (BTN_LVL),
        .IRQ     (IRQ)
    );

    // 100 MHz clock.
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Guard against any sequence that stalls.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Inputs change on the falling edge so they are stable at the rising edge.
    task automatic apbWrite(input logic [2:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
    endtask

    task automatic apbRead(input logic [2:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(negedge PCLK);
        PENABLE = 1'b1;
        data = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic readCheck(input string name, input logic [2:0] addr, input logic [31:0] expected);
        logic [31:0] d;
        apbRead(addr, d);
        checkOutput(name, d, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_write) begin
            apbWrite(v.addr, v.data);
        end else begin
            readCheck(v.name, v.addr, v.data);
        end
    endtask

    initial begin
        // Register table: reset values first, then write/readback behaviour.
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0000, "rst_status"};
        vecs[1]  = '{1'b0, 3'd1, 32'h0000_0000, "rst_event"};
        vecs[2]  = '{1'b0, 3'd2, 32'h0000_0000, "rst_irq_en"};
        vecs[3]  = '{1'b0, 3'd3, 32'd50000,     "rst_db_ticks"};
        vecs[4]  = '{1'b0, 3'd4, 32'h0000_0000, "rst_press_cnt"};
        vecs[5]  = '{1'b0, 3'd7, 32'h4244_0100, "rst_id"};
        vecs[6]  = '{1'b0, 3'd5, 32'h0000_0000, "rst_addr5"};
        vecs[7]  = '{1'b1, 3'd2, 32'hFFFF_A5A5, "wr_irq_en"};
        vecs[8]  = '{1'b0, 3'd2, 32'h0000_A5A5, "rd_irq_en"};
        vecs[9]  = '{1'b1, 3'd3, 32'h1234_0007, "wr_db_ticks"};
        vecs[10] = '{1'b0, 3'd3, 32'h0000_0007, "rd_db_ticks"};
        vecs[11] = '{1'b1, 3'd0, 32'h0000_00FF, "wr_status"};
        vecs[12] = '{1'b0, 3'd0, 32'h0000_0000, "rd_status_ro"};
        vecs[13] = '{1'b1, 3'd6, 32'hDEAD_BEEF, "wr_addr6"};
        vecs[14] = '{1'b0, 3'd6, 32'h0000_0000, "rd_addr6"};
        vecs[15] = '{1'b1, 3'd2, 32'h0000_0000, "clr_irq_en"};

        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
        BTN_IN = 2'b11;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;

        // ---- Reset state and register table ----
        $display("[TB] reset and register table");
        checkOutput("rst_irq",     {31'b0, IRQ},     32'h0);
        checkOutput("rst_btn_lvl", {30'b0, BTN_LVL}, 32'h0);
        checkOutput("pready",      {31'b0, PREADY},  32'h1);
        checkOutput("pslverr",     {31'b0, PSLVERR}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i]);
        end

        // ---- Press latency: 2 sync + DB_TICKS cycles, IRQ one cycle later ----
        $display("[TB] press latency");
        apbWrite(3'd3, 32'd4);
        apbWrite(3'd2, 32'h0000_0001);
        BTN_IN[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("lat_lvl_c%0d", k), {31'b0, BTN_LVL[0]}, {31'b0, (k >= 6)});
            checkOutput($sformatf("lat_irq_c%0d", k), {31'b0, IRQ},        {31'b0, (k >= 7)});
        end
        readCheck("lat_event", 3'd1, 32'h0000_0001);

        // Release, then acknowledge both events.
        BTN_IN[0] = 1'b1;
        repeat (10) @(negedge PCLK);
        checkOutput("rel_lvl", {31'b0, BTN_LVL[0]}, 32'h0);
        readCheck("rel_event", 3'd1, 32'h0000_0101);
        apbWrite(3'd1, 32'h0000_FFFF);
        readCheck("ack_event", 3'd1, 32'h0000_0000);

        // ---- Bounce: 3-cycle pulses never reach 4 stable cycles ----
        $display("[TB] bounce rejection");
        for (int t = 0; t < 10; t++) begin
            BTN_IN[0] = (t % 2 == 0) ? 1'b0 : 1'b1;
            repeat (3) begin
                @(negedge PCLK);
                checkOutput($sformatf("bounce_lvl_t%0d", t), {31'b0, BTN_LVL[0]}, 32'h0);
            end
        end
        BTN_IN[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge PCLK);
            checkOutput($sformatf("bounce_hold_c%0d", k), {31'b0, BTN_LVL[0]}, {31'b0, (k >= 6)});
        end
        readCheck("bounce_event", 3'd1, 32'h0000_0001);

        // ---- W1C race: release event and clear of bit 8 on the same edge ----
        $display("[TB] W1C race");
        apbWrite(3'd2, 32'h0000_0100);
        apbWrite(3'd1, 32'h0000_0001);
        readCheck("race_pre_event", 3'd1, 32'h0000_0000);
        BTN_IN[0] = 1'b1;
        repeat (3) @(negedge PCLK);
        apbWrite(3'd1, 32'h0000_0100);
        checkOutput("race_lvl", {31'b0, BTN_LVL[0]}, 32'h0);
        readCheck("race_event", 3'd1, 32'h0000_0100);
        checkOutput("race_irq_high", {31'b0, IRQ}, 32'h1);
        apbWrite(3'd1, 32'h0000_0100);
        checkOutput("race_irq_hold", {31'b0, IRQ}, 32'h1);
        @(negedge PCLK);
        checkOutput("race_irq_drop", {31'b0, IRQ}, 32'h0);
        readCheck("race_event_clr", 3'd1, 32'h0000_0000);

        // ---- Lowering DB_TICKS mid-count applies on the next edge ----
        $display("[TB] mid-count threshold");
        apbWrite(3'd2, 32'h0000_0000);
        apbWrite(3'd3, 32'd100);
        BTN_IN[1] = 1'b0;
        repeat (10) @(negedge PCLK);
        apbWrite(3'd3, 32'd5);
        checkOutput("mid_lvl_before", {31'b0, BTN_LVL[1]}, 32'h0);
        @(negedge PCLK);
        checkOutput("mid_lvl_after", {31'b0, BTN_LVL[1]}, 32'h1);
        readCheck("mid_event", 3'd1, 32'h0000_0002);
        readCheck("status_btn1", 3'd0, 32'h0000_0002);

        // ---- Reset asserted in the middle of a release debounce ----
        $display("[TB] reset mid-debounce");
        apbWrite(3'd2, 32'h0000_FFFF);
        apbWrite(3'd3, 32'd100);
        BTN_IN[1] = 1'b1;
        repeat (20) @(negedge PCLK);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (120) @(negedge PCLK);
        checkOutput("rstmid_lvl", {30'b0, BTN_LVL}, 32'h0);
        checkOutput("rstmid_irq", {31'b0, IRQ},     32'h0);
        readCheck("rstmid_event",    3'd1, 32'h0000_0000);
        readCheck("rstmid_irq_en",   3'd2, 32'h0000_0000);
        readCheck("rstmid_db_ticks", 3'd3, 32'd50000);

        // ---- Press counters: 300 presses on button 1 ----
        $display("[TB] press counters");
        apbWrite(3'd3, 32'd1);
        for (int n = 0; n < 300; n++) begin
            BTN_IN[1] = 1'b0;
            repeat (4) @(negedge PCLK);
            BTN_IN[1] = 1'b1;
            repeat (4) @(negedge PCLK);
        end
`ifdef BTN_PRESS_COUNT_EN
        readCheck("press_cnt_sat", 3'd4, 32'h0000_FF00);
        apbWrite(3'd4, 32'h0000_0000);
        readCheck("press_cnt_clr", 3'd4, 32'h0000_0000);
`else
        readCheck("press_cnt_off", 3'd4, 32'h0000_0000);
        apbWrite(3'd4, 32'hFFFF_FFFF);
        readCheck("press_cnt_off_wr", 3'd4, 32'h0000_0000);
`endif
        readCheck("cnt_event", 3'd1, 32'h0000_0202);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
